// File: rtl/paddle_emulator_pkg.sv
// rtl/paddle_emulator_pkg.sv - shared channel state encoding, clamp helper and defaults
package paddle_emulator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMED     = 2'd1,
        ST_FIRED     = 2'd2,
        ST_DISCHARGE = 2'd3
    } chan_state_t;

    localparam int DISCHARGE_LINE_DEFAULT = 256;

    function automatic logic [7:0] clamp_pos(input logic [7:0] pos,
                                             input logic [7:0] lo,
                                             input logic [7:0] hi);
        if (pos < lo) return lo;
        if (pos > hi) return hi;
        return pos;
    endfunction

endpackage

// File: rtl/paddle_emulator_channel.sv
// rtl/paddle_emulator_channel.sv - one emulated paddle: pending/committed position and pulse FSM
module paddle_channel
    import paddle_emulator_pkg::*;
#(
    parameter int RESET_POS      = 128,
    parameter int PADDLE_MIN     = 0,
    parameter int PADDLE_MAX     = 239,
    parameter int DISCHARGE_LINE = DISCHARGE_LINE_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] vpos,
    input  logic       fs_cond,
    input  logic [7:0] pos,
    input  logic       load,
    output logic       paddle
);

    localparam logic [7:0] RESET_VAL = 8'(RESET_POS);
    localparam logic [7:0] MIN_VAL   = 8'(PADDLE_MIN);
    localparam logic [7:0] MAX_VAL   = 8'(PADDLE_MAX);
    localparam logic [8:0] DIS_VAL   = 9'(DISCHARGE_LINE);

    chan_state_t state;
    chan_state_t next_state;
    logic [7:0]  pending;
    logic [7:0]  committed;
    logic [7:0]  load_val;

    assign load_val = clamp_pos(pos, MIN_VAL, MAX_VAL);

    // A load landing on the frame-start cycle takes effect in that same frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending   <= RESET_VAL;
            committed <= RESET_VAL;
        end else begin
            if (load) pending <= load_val;
            if (fs_cond) committed <= load ? load_val : pending;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (fs_cond) next_state = ST_ARMED;
            end
            ST_ARMED: begin
                if (!fs_cond && !vpos[8] && (vpos[7:0] >= committed)) next_state = ST_FIRED;
            end
            ST_FIRED: begin
                if (fs_cond)              next_state = ST_ARMED;
                else if (vpos >= DIS_VAL) next_state = ST_DISCHARGE;
            end
            ST_DISCHARGE: begin
                if (fs_cond) next_state = ST_ARMED;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        paddle = (state == ST_FIRED);
    end

endmodule

// File: rtl/paddle_emulator.sv
// rtl/paddle_emulator.sv - scanline-timed horizontal/vertical paddle pulse emulator
module paddle_emulator
    import paddle_emulator_pkg::*;
#(
    parameter int RESET_POS      = 128,
    parameter int PADDLE_MIN     = 0,
    parameter int PADDLE_MAX     = 239,
    parameter int DISCHARGE_LINE = DISCHARGE_LINE_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] vpos,
    input  logic [7:0] pos_x,
    input  logic       load_x,
    input  logic [7:0] pos_y,
    input  logic       load_y,
    output logic       hpaddle,
    output logic       vpaddle,
    output logic       frame_start
);

    logic [8:0] prev_vpos;
    logic       fs_cond;

    // New frame is the wrap back to line 0, not merely sitting on line 0.
    assign fs_cond = (vpos == 9'd0) && (prev_vpos != 9'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_vpos   <= 9'd0;
            frame_start <= 1'b0;
        end else begin
            prev_vpos   <= vpos;
            frame_start <= fs_cond;
        end
    end

    paddle_channel #(
        .RESET_POS      (RESET_POS),
        .PADDLE_MIN     (PADDLE_MIN),
        .PADDLE_MAX     (PADDLE_MAX),
        .DISCHARGE_LINE (DISCHARGE_LINE)
    ) u_chan_x (
        .clk     (clk),
        .reset   (reset),
        .vpos    (vpos),
        .fs_cond (fs_cond),
        .pos     (pos_x),
        .load    (load_x),
        .paddle  (hpaddle)
    );

    paddle_channel #(
        .RESET_POS      (RESET_POS),
        .PADDLE_MIN     (PADDLE_MIN),
        .PADDLE_MAX     (PADDLE_MAX),
        .DISCHARGE_LINE (DISCHARGE_LINE)
    ) u_chan_y (
        .clk     (clk),
        .reset   (reset),
        .vpos    (vpos),
        .fs_cond (fs_cond),
        .pos     (pos_y),
        .load    (load_y),
        .paddle  (vpaddle)
    );

endmodule

// File: tb/tb_paddle_emulator.sv
// tb/tb_paddle_emulator.sv - directed self-checking bench for paddle_emulator
module tb_paddle_emulator;

    localparam int LINE_CLKS = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] vpos;
    logic [7:0] pos_x, pos_y;
    logic       load_x, load_y;
    logic       hpaddle, vpaddle, frame_start;

    int checks   = 0;
    int failures = 0;

    int         h_rises = 0, v_rises = 0, fs_cycles = 0;
    logic [8:0] h_rise_v = '0, v_rise_v = '0, h_fall_v = '0, v_fall_v = '0;
    logic       hp_q = 1'b0, vp_q = 1'b0;
    int         h0, v0, f0;

    always #5 clk = ~clk;

    paddle_emulator dut (
        .clk         (clk),
        .reset       (reset),
        .vpos        (vpos),
        .pos_x       (pos_x),
        .load_x      (load_x),
        .pos_y       (pos_y),
        .load_y      (load_y),
        .hpaddle     (hpaddle),
        .vpaddle     (vpaddle),
        .frame_start (frame_start)
    );

    // Paddle reader: latches the scanline on each edge of the pulses.
    always @(negedge clk) begin
        if (hpaddle && !hp_q) begin h_rises++; h_rise_v = vpos; end
        if (!hpaddle && hp_q) h_fall_v = vpos;
        if (vpaddle && !vp_q) begin v_rises++; v_rise_v = vpos; end
        if (!vpaddle && vp_q) v_fall_v = vpos;
        if (frame_start) fs_cycles++;
        hp_q = hpaddle;
        vp_q = vpaddle;
    end

    task automatic run_lines(input int a, input int b);
        for (int v = a; v <= b; v++) begin
            vpos = 9'(v);
            repeat (LINE_CLKS) @(posedge clk);
            #1;
        end
    endtask

    task automatic load_line(input int v, input bit is_y, input logic [7:0] p);
        vpos = 9'(v);
        if (is_y) begin pos_y = p; load_y = 1'b1; end
        else      begin pos_x = p; load_x = 1'b1; end
        @(posedge clk);
        #1;
        load_x = 1'b0;
        load_y = 1'b0;
        repeat (LINE_CLKS - 1) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        h0 = h_rises;
        v0 = v_rises;
        f0 = fs_cycles;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (hpaddle !== 1'b0) begin failures++; $display("FAIL reset_hpaddle: got %b expected 0", hpaddle); end
        checks++; if (vpaddle !== 1'b0) begin failures++; $display("FAIL reset_vpaddle: got %b expected 0", vpaddle); end
        checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL reset_frame_start: got %b expected 0", frame_start); end
        reset = 1'b1;
        snap();
        run_lines(0, 261);
        checks++; if (h_rises - h0 != 0) begin failures++; $display("FAIL pre_frame_h_rises: got %0d expected 0", h_rises - h0); end
        checks++; if (v_rises - v0 != 0) begin failures++; $display("FAIL pre_frame_v_rises: got %0d expected 0", v_rises - v0); end
        checks++; if (fs_cycles - f0 != 0) begin failures++; $display("FAIL pre_frame_fs: got %0d expected 0", fs_cycles - f0); end
    endtask

    task automatic test_default_frame();
        snap();
        run_lines(0, 261);
        checks++; if (h_rises - h0 != 1) begin failures++; $display("FAIL default_h_count: got %0d expected 1", h_rises - h0); end
        checks++; if (h_rise_v !== 9'd128) begin failures++; $display("FAIL default_h_rise: got %0d expected 128", h_rise_v); end
        checks++; if (h_fall_v !== 9'd256) begin failures++; $display("FAIL default_h_fall: got %0d expected 256", h_fall_v); end
        checks++; if (v_rise_v !== 9'd128) begin failures++; $display("FAIL default_v_rise: got %0d expected 128", v_rise_v); end
        checks++; if (v_fall_v !== 9'd256) begin failures++; $display("FAIL default_v_fall: got %0d expected 256", v_fall_v); end
        checks++; if (fs_cycles - f0 != 1) begin failures++; $display("FAIL default_fs: got %0d expected 1", fs_cycles - f0); end
    endtask

    task automatic test_reset_mid_frame();
        run_lines(0, 200);
        checks++; if (hpaddle !== 1'b1) begin failures++; $display("FAIL mid_pre_hpaddle: got %b expected 1", hpaddle); end
        #2 reset = 1'b0;
        #1;
        checks++; if (hpaddle !== 1'b0) begin failures++; $display("FAIL mid_reset_hpaddle: got %b expected 0", hpaddle); end
        checks++; if (vpaddle !== 1'b0) begin failures++; $display("FAIL mid_reset_vpaddle: got %b expected 0", vpaddle); end
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        snap();
        run_lines(201, 261);
        checks++; if (h_rises - h0 != 0) begin failures++; $display("FAIL mid_after_h_rises: got %0d expected 0", h_rises - h0); end
        snap();
        run_lines(0, 261);
        checks++; if (h_rises - h0 != 1) begin failures++; $display("FAIL mid_resume_h_count: got %0d expected 1", h_rises - h0); end
        checks++; if (h_rise_v !== 9'd128) begin failures++; $display("FAIL mid_resume_h_rise: got %0d expected 128", h_rise_v); end
    endtask

    task automatic test_load_x();
        snap();
        run_lines(0, 9);
        load_line(10, 1'b0, 8'd100);
        run_lines(11, 261);
        checks++; if (h_rise_v !== 9'd128) begin failures++; $display("FAIL loadx_same_frame: got %0d expected 128", h_rise_v); end
        snap();
        run_lines(0, 261);
        checks++; if (h_rises - h0 != 1) begin failures++; $display("FAIL loadx_count: got %0d expected 1", h_rises - h0); end
        checks++; if (h_rise_v !== 9'd100) begin failures++; $display("FAIL loadx_rise: got %0d expected 100", h_rise_v); end
        checks++; if (h_fall_v !== 9'd256) begin failures++; $display("FAIL loadx_fall: got %0d expected 256", h_fall_v); end
    endtask

    task automatic test_clamp_y();
        run_lines(0, 19);
        load_line(20, 1'b1, 8'd250);
        run_lines(21, 261);
        run_lines(0, 29);
        load_line(30, 1'b1, 8'd0);
        run_lines(31, 261);
        checks++; if (v_rise_v !== 9'd239) begin failures++; $display("FAIL clamp_max_rise: got %0d expected 239", v_rise_v); end
        checks++; if (h_rise_v !== 9'd100) begin failures++; $display("FAIL clamp_x_indep: got %0d expected 100", h_rise_v); end
        snap();
        run_lines(0, 261);
        checks++; if (v_rises - v0 != 1) begin failures++; $display("FAIL pos0_count: got %0d expected 1", v_rises - v0); end
        checks++; if (v_rise_v !== 9'd0) begin failures++; $display("FAIL pos0_rise: got %0d expected 0", v_rise_v); end
    endtask

    task automatic test_load_at_fs();
        snap();
        load_line(0, 1'b0, 8'd50);
        run_lines(1, 261);
        checks++; if (h_rises - h0 != 1) begin failures++; $display("FAIL fsload_count: got %0d expected 1", h_rises - h0); end
        checks++; if (h_rise_v !== 9'd50) begin failures++; $display("FAIL fsload_rise: got %0d expected 50", h_rise_v); end
    endtask

    task automatic test_skipped_line();
        snap();
        run_lines(0, 40);
        run_lines(60, 261);
        checks++; if (h_rises - h0 != 1) begin failures++; $display("FAIL skip_count: got %0d expected 1", h_rises - h0); end
        checks++; if (h_rise_v !== 9'd60) begin failures++; $display("FAIL skip_rise: got %0d expected 60", h_rise_v); end
    endtask

    task automatic test_loopback();
        run_lines(0, 4);
        load_line(5, 1'b0, 8'd17);
        load_line(6, 1'b1, 8'd200);
        run_lines(7, 261);
        for (int f = 0; f < 3; f++) begin
            snap();
            run_lines(0, 261);
            checks++; if (h_rise_v !== 9'd17) begin failures++; $display("FAIL loop_x frame %0d: got %0d expected 17", f, h_rise_v); end
            checks++; if (v_rise_v !== 9'd200) begin failures++; $display("FAIL loop_y frame %0d: got %0d expected 200", f, v_rise_v); end
            checks++; if (h_rises - h0 != 1) begin failures++; $display("FAIL loop_x_count frame %0d: got %0d expected 1", f, h_rises - h0); end
            checks++; if (v_rises - v0 != 1) begin failures++; $display("FAIL loop_y_count frame %0d: got %0d expected 1", f, v_rises - v0); end
            checks++; if (fs_cycles - f0 != 1) begin failures++; $display("FAIL loop_fs frame %0d: got %0d expected 1", f, fs_cycles - f0); end
        end
    endtask

    initial begin
        reset  = 1'b0;
        vpos   = 9'd0;
        pos_x  = 8'd0;
        pos_y  = 8'd0;
        load_x = 1'b0;
        load_y = 1'b0;
        test_reset();
        test_default_frame();
        test_reset_mid_frame();
        test_load_x();
        test_clamp_y();
        test_load_at_fs();
        test_skipped_line();
        test_loopback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
